// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, prefetches sequential words into a small FIFO and redirects on taken branches.
// Define FETCH_PERF_EN to add the perf_fetched / perf_flushed counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  input  logic        instr_ready,
  input  logic        pc_src,
  input  logic [31:0] imm_ext
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_flushed
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   fetchPc_q, fetchPc_d;
  logic [31:0]   respPc_q, respPc_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] discard_q, discard_d;
  logic [PW-1:0] rdPtr_q, rdPtr_d;
  logic [PW-1:0] wrPtr_q, wrPtr_d;
  logic [31:0]   pcMem_q    [FIFO_DEPTH];
  logic [31:0]   instrMem_q [FIFO_DEPTH];

  logic        accept, redirect, credit, issue, resp, drop, push, pop;
  logic [31:0] target;

  assign instr_valid = (count_q != '0);
  assign pc_o        = instr_valid ? pcMem_q[rdPtr_q]    : '0;
  assign instr_o     = instr_valid ? instrMem_q[rdPtr_q] : '0;

  assign accept   = instr_valid & instr_ready;
  assign redirect = accept & pc_src;
  assign target   = (pc_o + imm_ext) & 32'hFFFF_FFFC;

  // Credit counts buffered plus in-flight words, so a response can never find the FIFO full.
  assign credit    = ({1'b0, count_q} + {1'b0, outst_q}) < (CW+1)'(FIFO_DEPTH);
  assign imem_req  = ~rst & ~redirect & credit;
  assign imem_addr = fetchPc_q;

  assign issue = imem_req & imem_gnt;
  assign resp  = imem_rvalid & (outst_q != '0);
  assign drop  = resp & (discard_q != '0);
  assign push  = resp & ~drop & ~redirect;
  assign pop   = accept & ~redirect;

  always_comb begin
    fetchPc_d = fetchPc_q;
    respPc_d  = respPc_q;
    outst_d   = outst_q + CW'(issue) - CW'(resp);
    discard_d = discard_q - CW'(drop);
    count_d   = count_q + CW'(push) - CW'(pop);
    rdPtr_d   = rdPtr_q + PW'(pop);
    wrPtr_d   = wrPtr_q + PW'(push);
    if (issue) fetchPc_d = fetchPc_q + 32'd4;
    if (resp && !drop) respPc_d = respPc_q + 32'd4;
    // Every request still in flight after a redirect belongs to the old path.
    if (redirect) begin
      fetchPc_d = target;
      respPc_d  = target;
      discard_d = outst_q - CW'(resp);
      count_d   = '0;
      rdPtr_d   = '0;
      wrPtr_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetchPc_q <= RESET_PC;
      respPc_q  <= RESET_PC;
      count_q   <= '0;
      outst_q   <= '0;
      discard_q <= '0;
      rdPtr_q   <= '0;
      wrPtr_q   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        pcMem_q[i]    <= '0;
        instrMem_q[i] <= '0;
      end
    end else begin
      fetchPc_q <= fetchPc_d;
      respPc_q  <= respPc_d;
      count_q   <= count_d;
      outst_q   <= outst_d;
      discard_q <= discard_d;
      rdPtr_q   <= rdPtr_d;
      wrPtr_q   <= wrPtr_d;
      if (push) begin
        pcMem_q[wrPtr_q]    <= respPc_q;
        instrMem_q[wrPtr_q] <= imem_rdata;
      end
    end
  end

  assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && (count_q == CW'(FIFO_DEPTH))));

`ifdef FETCH_PERF_EN
  logic [31:0] perfFetched_q, perfFlushed_q;

  // A redirect flushes the entries behind the accepted head plus any same-cycle response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perfFetched_q <= '0;
      perfFlushed_q <= '0;
    end else begin
      if (accept) perfFetched_q <= perfFetched_q + 32'd1;
      if (redirect)
        perfFlushed_q <= perfFlushed_q + 32'(count_q) - 32'd1 + 32'(resp);
      else if (drop)
        perfFlushed_q <= perfFlushed_q + 32'd1;
    end
  end

  assign perf_fetched = perfFetched_q;
  assign perf_flushed = perfFlushed_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: an in-order memory model, a PC-stream reference model and
// randomized handshake/branch stimulus, with directed reset, redirect and wrap scenarios.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        instr_valid;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        instr_ready = 1'b0;
  logic        pc_src = 1'b0;
  logic [31:0] imm_ext = '0;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_o(instr_o), .pc_o(pc_o),
    .instr_ready(instr_ready), .pc_src(pc_src), .imm_ext(imm_ext)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } memReq_t;

  memReq_t     memQ[$];
  logic [31:0] expQ[$];
  logic [31:0] modelPc = RESET_PC;
  logic [31:0] monExp;
  logic        acc;
  int cyc = 0, lat = 1, lastDue = 0, gntMode = 0, maxInFlight = 0;
  int total = 0, bad = 0;
  bit injectStale = 0;

  // Memory contents are a fixed scramble of the address, so any word can be predicted.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a ^ 32'h5A3C_96E1) + {a[15:0], a[31:16]};
  endfunction

  function automatic logic nextGnt();
    case (gntMode)
      0:       return 1'b1;
      1:       return cyc[0];
      2:       return 1'($urandom_range(0, 1));
      default: return 1'b0;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic reportFail(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s: bound expired", name);
  endtask

  // Memory side: record every granted request with its response cycle, in issue order.
  task automatic sampleIssue();
    memReq_t r;
    if (imem_req && imem_gnt) begin
      r.addr  = imem_addr;
      r.due   = (cyc + lat > lastDue) ? cyc + lat : lastDue + 1;
      lastDue = r.due;
      memQ.push_back(r);
    end
    if (memQ.size() > maxInFlight) maxInFlight = memQ.size();
  endtask

  // One clock: drive memory and downstream inputs after the edge, then sample requests mid-cycle.
  task automatic applyStimulus(input logic rdy, input logic br, input logic [31:0] imm, output logic accepted);
    @(posedge clk);
    #1;
    cyc++;
    if (memQ.size() > 0 && memQ[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = memWord(memQ[0].addr);
      void'(memQ.pop_front());
    end else if (injectStale) begin
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hDEAD_BEEF;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    imem_gnt    = nextGnt();
    instr_ready = rdy;
    pc_src      = br;
    imm_ext     = imm;
    accepted    = instr_valid && rdy;
    if (accepted) begin
      expQ.push_back(modelPc);
      modelPc = br ? ((modelPc + imm) & 32'hFFFF_FFFC) : modelPc + 32'd4;
    end
    @(negedge clk);
    sampleIssue();
  endtask

  task automatic doReset();
    #2;
    rst         = 1'b1;
    imem_rvalid = 1'b0;
    imem_gnt    = 1'b0;
    instr_ready = 1'b0;
    pc_src      = 1'b0;
    imm_ext     = '0;
    #1;
    checkOutput("reset instr_valid", 32'(instr_valid), 32'd0);
    checkOutput("reset imem_req", 32'(imem_req), 32'd0);
    checkOutput("reset pc_o", pc_o, 32'd0);
    checkOutput("reset instr_o", instr_o, 32'd0);
    memQ.delete();
    expQ.delete();
    modelPc = RESET_PC;
    lastDue = 0;
    repeat (3) @(posedge clk);
    #1;
    cyc++;
    rst      = 1'b0;
    imem_gnt = nextGnt();
    @(negedge clk);
    sampleIssue();
  endtask

  task automatic acceptHead(input logic br, input logic [31:0] imm);
    logic got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) applyStimulus(1'b1, br, imm, got);
    if (!got) reportFail("accept head");
  endtask

  task automatic waitValid(input string name);
    logic dummy;
    for (int i = 0; i < 30 && !instr_valid; i++) applyStimulus(1'b0, 1'b0, 32'd0, dummy);
    if (!instr_valid) reportFail(name);
  endtask

  task automatic runRandom(input int n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] r;
      logic [31:0] imm;
      logic        a;
      r   = $urandom;
      imm = ($urandom_range(0, 3) == 0) ? $urandom : {{20{r[11]}}, r[11:0]};
      applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0), imm, a);
    end
  endtask

  // Monitor: every accepted head must match the next PC the reference model predicted.
  always @(negedge clk) begin
    if (!rst && instr_valid && instr_ready) begin
      if (expQ.size() == 0) begin
        reportFail("scoreboard empty on accept");
      end else begin
        monExp = expQ.pop_front();
        checkOutput("head pc", pc_o, monExp);
        checkOutput("head instr", instr_o, memWord(monExp));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // Streaming from reset with a one-cycle memory.
    lat = 1;
    gntMode = 0;
    doReset();
    applyStimulus(1'b0, 1'b0, 32'd0, acc);
    checkOutput("valid one cycle after reset", 32'(instr_valid), 32'd0);
    applyStimulus(1'b0, 1'b0, 32'd0, acc);
    checkOutput("valid two cycles after reset", 32'(instr_valid), 32'd1);
    checkOutput("first pc", pc_o, RESET_PC);
    for (int i = 0; i < 12; i++) applyStimulus(1'b1, 1'b0, 32'd0, acc);

    // Back-pressure fills the FIFO and stops prefetch.
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 32'd0, acc);
    checkOutput("stalled imem_req", 32'(imem_req), 32'd0);
    checkOutput("stalled outstanding", 32'(memQ.size()), 32'd0);
    checkOutput("stalled valid", 32'(instr_valid), 32'd1);
    checkOutput("stalled head pc", pc_o, modelPc);
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 32'd0, acc);

    // Taken branch at pc 0x8 with offset 0x100.
    doReset();
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 32'd0, acc);
    acceptHead(1'b0, 32'd0);
    acceptHead(1'b0, 32'd0);
    acceptHead(1'b1, 32'h0000_0100);
    checkOutput("redirect cycle req", 32'(imem_req), 32'd0);
    applyStimulus(1'b0, 1'b0, 32'd0, acc);
    checkOutput("valid after redirect", 32'(instr_valid), 32'd0);
    waitValid("branch target arrival");
    checkOutput("branch target pc", pc_o, 32'h0000_0108);
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 32'd0, acc);

    // Negative offset from pc 0x4 wraps the fetch address below zero.
    doReset();
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 32'd0, acc);
    acceptHead(1'b0, 32'd0);
    acceptHead(1'b1, 32'hFFFF_FFF8);
    checkOutput("wrap redirect req", 32'(imem_req), 32'd0);
    applyStimulus(1'b0, 1'b0, 32'd0, acc);
    checkOutput("wrap req after redirect", 32'(imem_req), 32'd1);
    checkOutput("wrap addr", imem_addr, 32'hFFFF_FFFC);
    applyStimulus(1'b0, 1'b0, 32'd0, acc);
    checkOutput("wrap next addr", imem_addr, 32'h0000_0000);
    waitValid("wrap target arrival");
    checkOutput("wrap target pc", pc_o, 32'hFFFF_FFFC);
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 32'd0, acc);

    // Randomized traffic under slow and irregular memory.
    lat = 3;
    gntMode = 1;
    maxInFlight = 0;
    runRandom(1500);
    checkOutput("max outstanding", 32'(maxInFlight), 32'(DEPTH));
    lat = 2;
    gntMode = 2;
    runRandom(1500);
    lat = 1;
    gntMode = 0;
    runRandom(1000);
    checkOutput("max outstanding overall", 32'(maxInFlight), 32'(DEPTH));

    // Reset with two requests in flight; stale responses afterwards must be ignored.
    lat = 3;
    gntMode = 0;
    doReset();
    for (int i = 0; i < 10 && memQ.size() < 2; i++) applyStimulus(1'b0, 1'b0, 32'd0, acc);
    checkOutput("outstanding before reset", 32'(memQ.size()), 32'd2);
    gntMode = 3;
    doReset();
    injectStale = 1;
    applyStimulus(1'b0, 1'b0, 32'd0, acc);
    applyStimulus(1'b0, 1'b0, 32'd0, acc);
    injectStale = 0;
    applyStimulus(1'b0, 1'b0, 32'd0, acc);
    checkOutput("stale response ignored", 32'(instr_valid), 32'd0);
    checkOutput("post-reset addr", imem_addr, RESET_PC);
    checkOutput("post-reset req", 32'(imem_req), 32'd1);
    gntMode = 0;
    waitValid("post-reset first fetch");
    checkOutput("post-reset first pc", pc_o, RESET_PC);
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 32'd0, acc);

    checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
